pe_array_db: RTL and testbench



---
 rtl/pe_array_db.sv | 186 ++++++++++++++++++
 tb/tb_pe_array_db.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_db.sv
// Double-buffered weight-stationary systolic MAC array with per-row input
// buffers, a skewed-issue run controller and a shadow weight bank.
module pe_array_db #(
  parameter int array_width  = 8,
  parameter int array_height = 8,
  parameter int x_w          = 8,
  parameter int w_w          = 8,
  parameter int mac_w        = 19,
  parameter int rbuf_depth   = 8
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [w_w-1:0]                                     w_i,
  input  logic [$clog2(array_width*array_height)-1:0]        w_addr_i,
  input  logic                                               w_en_i,
  input  logic [$clog2(array_height)+$clog2(rbuf_depth)-1:0] rbuf_waddr_i,
  input  logic [x_w-1:0]                                     rbuf_wdata_i,
  input  logic                                               rbuf_w_vi,
  input  logic [$clog2(rbuf_depth):0]                        len_i,
  input  logic                                               start_i,
  input  logic                                               swap_i,
  output logic [array_width*mac_w-1:0]                       mac_o,
  output logic [array_width-1:0]                             mac_v_o,
  output logic                                               busy_o,
  output logic                                               done_o,
  output logic                                               wr_drop_o
);
  localparam int W  = array_width;
  localparam int H  = array_height;
  localparam int D  = rbuf_depth;
  localparam int RW = $clog2(H);
  localparam int DW = $clog2(D);
  localparam int LW = DW + 1;
  localparam int CW = $clog2(H + W + D + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic          swap_pend;
  logic          copy_now;
  logic          wr_ok;
  logic [RW-1:0] wr_row;
  logic [DW-1:0] wr_ent;

  logic [w_w-1:0] shadow [W*H];
  logic [w_w-1:0] active [W*H];
  logic [x_w-1:0] rbuf   [H][D];

  logic [CW-1:0]  rel     [H];
  logic [DW-1:0]  rd_idx  [H];
  logic           issue   [H];
  logic [x_w-1:0] rbuf_rd [H];

  logic [x_w-1:0]   xr  [H][W];
  logic             xv  [H][W];
  logic [mac_w-1:0] acc [H][W];
  logic             av  [H][W];

  assign busy_o = (state != IDLE);
  assign wr_row = rbuf_waddr_i[RW+DW-1:DW];
  assign wr_ent = rbuf_waddr_i[DW-1:0];
  assign wr_ok  = !busy_o && (32'(wr_row) < H);
  // A request arriving in the done cycle itself merges with any pending one.
  assign copy_now = ((state == IDLE) && swap_i) || (done_o && (swap_pend || swap_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      done_o    <= 1'b0;
      wr_drop_o <= 1'b0;
      swap_pend <= 1'b0;
      for (int unsigned k = 0; k < W*H; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      done_o    <= 1'b0;
      wr_drop_o <= rbuf_w_vi && !wr_ok;
      if (w_en_i && (32'(w_addr_i) < W*H))
        shadow[w_addr_i] <= w_i;
      if (copy_now)
        for (int unsigned k = 0; k < W*H; k++)
          active[k] <= shadow[k];
      if (done_o)
        swap_pend <= 1'b0;
      else if (swap_i && busy_o)
        swap_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i && (len_i != '0)) begin
            state <= RUN;
            cnt   <= '0;
            len_q <= (len_i > LW'(D)) ? LW'(D) : len_i;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(H) + CW'(len_q) - CW'(2))
            state <= DRAIN;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(H) + CW'(W) + CW'(len_q) - CW'(1))
            done_o <= 1'b1;
          if (done_o)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rbuf_w_vi && wr_ok)
      rbuf[wr_row][wr_ent] <= rbuf_wdata_i;
  end

  // Row i trails row 0 by i cycles: it reads entry cnt-i while that is in 0..L-1.
  always_comb begin
    for (int unsigned i = 0; i < H; i++) begin
      rel[i]     = cnt - CW'(i);
      rd_idx[i]  = rel[i][DW-1:0];
      issue[i]   = (state == RUN) && (cnt >= CW'(i)) && (rel[i] < CW'(len_q));
      rbuf_rd[i] = rbuf[i][rd_idx[i]];
    end
  end

  for (genvar gi = 0; gi < H; gi++) begin : g_row
    for (genvar gj = 0; gj < W; gj++) begin : g_pe
      logic [x_w-1:0]   x_src;
      logic             v_src;
      logic [mac_w-1:0] acc_in;
      logic [x_w-1:0]   x_q;
      logic             xv_q;
      logic [mac_w-1:0] acc_q;
      logic             av_q;

      if (gj == 0) begin : g_feed
        assign x_src = rbuf_rd[gi];
        assign v_src = issue[gi];
      end else begin : g_pass
        assign x_src = xr[gi][gj-1];
        assign v_src = xv[gi][gj-1];
      end

      if (gi == 0) begin : g_top
        assign acc_in = '0;
      end else begin : g_chain
        assign acc_in = acc[gi-1][gj];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          x_q   <= '0;
          xv_q  <= 1'b0;
          acc_q <= '0;
          av_q  <= 1'b0;
        end else begin
          xv_q <= v_src;
          av_q <= xv_q;
          if (v_src)
            x_q <= x_src;
          if (xv_q)
            acc_q <= acc_in + mac_w'(x_q) * mac_w'(active[gi*W+gj]);
        end
      end

      assign xr[gi][gj]  = x_q;
      assign xv[gi][gj]  = xv_q;
      assign acc[gi][gj] = acc_q;
      assign av[gi][gj]  = av_q;
    end
  end

  for (genvar gj = 0; gj < W; gj++) begin : g_out
    assign mac_o[gj*mac_w +: mac_w] = acc[H-1][gj];
    assign mac_v_o[gj]              = av[H-1][gj];
  end

endmodule

// File: tb/tb_pe_array_db.sv
// Directed bench for pe_array_db: identity, shadow swap, length clamp,
// saturation-sized products and mid-run reset, all checked cycle-exactly.
module tb_pe_array_db;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int MW = 19;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [7:0]    w_i;
  logic [5:0]    w_addr_i;
  logic          w_en_i;
  logic [5:0]    rbuf_waddr_i;
  logic [7:0]    rbuf_wdata_i;
  logic          rbuf_w_vi;
  logic [3:0]    len_i;
  logic          start_i;
  logic          swap_i;
  logic [W*MW-1:0] mac_o;
  logic [W-1:0]  mac_v_o;
  logic          busy_o;
  logic          done_o;
  logic          wr_drop_o;

  int errors = 0;
  int checks = 0;

  pe_array_db #(
    .array_width(8), .array_height(8), .x_w(8), .w_w(8), .mac_w(19), .rbuf_depth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .w_i(w_i), .w_addr_i(w_addr_i), .w_en_i(w_en_i),
    .rbuf_waddr_i(rbuf_waddr_i), .rbuf_wdata_i(rbuf_wdata_i), .rbuf_w_vi(rbuf_w_vi),
    .len_i(len_i), .start_i(start_i), .swap_i(swap_i), .mac_o(mac_o),
    .mac_v_o(mac_v_o), .busy_o(busy_o), .done_o(done_o), .wr_drop_o(wr_drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] col(input int j);
    return 32'(mac_o[j*MW +: MW]);
  endfunction

  // mode 0: identity data x[j][t]=8t+j+1 times scale; 1: 8*255*255; 2: zero weights
  function automatic logic [31:0] exp_val(input int mode, input int scale, input int t, input int j);
    case (mode)
      0:       return 32'(scale * (8*t + j + 1));
      1:       return 32'd520200;
      default: return 32'd0;
    endcase
  endfunction

  task automatic write_buf(input int row, input int ent, input int val);
    rbuf_waddr_i = 6'(row*8 + ent);
    rbuf_wdata_i = 8'(val);
    rbuf_w_vi    = 1'b1;
    tick();
    rbuf_w_vi    = 1'b0;
  endtask

  task automatic write_w(input int addr, input int val);
    w_addr_i = 6'(addr);
    w_i      = 8'(val);
    w_en_i   = 1'b1;
    tick();
    w_en_i   = 1'b0;
  endtask

  // Cycle k is observed 1 time unit after edge k; edge 0 accepts start.
  task automatic do_run(input int len, input int L, input int mode, input int scale,
                        input bit sw, input bit side);
    int  t;
    bit  vexp;
    start_i = 1'b1;
    len_i   = 4'(len);
    swap_i  = sw;
    tick();
    start_i = 1'b0;
    swap_i  = 1'b0;
    len_i   = '0;
    check("busy_c0", 32'(busy_o), 32'd1);
    for (int k = 1; k <= H+W+L+2; k++) begin
      tick();
      for (int j = 0; j < W; j++) begin
        t    = k - (H + 1 + j);
        vexp = (t >= 0) && (t < L);
        check($sformatf("vld k%0d c%0d", k, j), 32'(mac_v_o[j]), 32'(vexp));
        if (vexp)
          check($sformatf("mac t%0d c%0d", t, j), col(j), exp_val(mode, scale, t, j));
      end
      check($sformatf("done k%0d", k), 32'(done_o), 32'(k == H+W+L));
      check($sformatf("busy k%0d", k), 32'(busy_o), 32'(k <= H+W+L));
      check($sformatf("drop k%0d", k), 32'(wr_drop_o), 32'(side && (k == 6)));
      if (side) begin
        if (k >= 2 && k <= 9) begin
          w_en_i   = 1'b1;
          w_addr_i = 6'((k-2)*9);
          w_i      = 8'd2;
        end else begin
          w_en_i = 1'b0;
        end
        rbuf_w_vi = (k == 5);
        if (k == 5) begin
          rbuf_waddr_i = '0;
          rbuf_wdata_i = 8'hEE;
        end
        swap_i = (k == 12);
      end
    end
  endtask

  initial begin
    bit seen;
    rst_i = 1'b1; w_i = '0; w_addr_i = '0; w_en_i = 1'b0; rbuf_waddr_i = '0;
    rbuf_wdata_i = '0; rbuf_w_vi = 1'b0; len_i = '0; start_i = 1'b0; swap_i = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_drop", 32'(wr_drop_o), 32'd0);
    check("rst_vld", 32'(mac_v_o), 32'd0);
    check("rst_mac0", col(0), 32'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < H; i++)
      for (int t = 0; t < 8; t++)
        write_buf(i, t, 8*t + i + 1);
    for (int i = 0; i < H; i++)
      write_w(i*9, 1);
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    tick();

    // identity run; shadow rewritten to 2*I, swap requested and a write dropped mid-run
    do_run(8, 8, 0, 1, 1'b0, 1'b1);
    tick();
    do_run(8, 8, 0, 2, 1'b0, 1'b0);
    tick();

    start_i = 1'b1;
    len_i   = '0;
    tick();
    start_i = 1'b0;
    check("len0_busy_a", 32'(busy_o), 32'd0);
    tick();
    check("len0_busy_b", 32'(busy_o), 32'd0);
    check("len0_vld", 32'(mac_v_o), 32'd0);

    do_run(15, 8, 0, 2, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < H; i++)
      for (int t = 0; t < 8; t++)
        write_buf(i, t, 255);
    for (int a = 0; a < W*H; a++)
      write_w(a, 255);
    do_run(8, 8, 1, 1, 1'b1, 1'b0);
    tick();

    start_i = 1'b1;
    len_i   = 4'd8;
    tick();
    start_i = 1'b0;
    len_i   = '0;
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    check("mrst_vld", 32'(mac_v_o), 32'd0);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_mac0", col(0), 32'd0);
    check("mrst_mac7", col(7), 32'd0);
    rst_i = 1'b0;
    seen  = 1'b0;
    repeat (30) begin
      tick();
      if (done_o)
        seen = 1'b1;
    end
    check("mrst_no_done", 32'(seen), 32'd0);
    do_run(8, 8, 2, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
